// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared definitions for the sequential ALU control decoder.
//   - 4-bit ALU control codes
//   - 11-bit R-format opcode patterns
//   - alu_op encodings
//   - FSM state enum
package alu_ctrl_pkg;

  localparam int DEC_W  = 11;  // opcode bits examined by the decoder (MSB-aligned)
  localparam int CODE_W = 4;   // native ALU control code width

  typedef enum logic [CODE_W-1:0] {
    ALU_AND   = 4'b0000,
    ALU_OR    = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_EOR   = 4'b0011,
    ALU_LSL   = 4'b0100,
    ALU_LSR   = 4'b0101,
    ALU_SUB   = 4'b0110,
    ALU_PASSB = 4'b0111,
    ALU_MUL   = 4'b1000
  } alu_code_e;

  localparam logic [DEC_W-1:0] OP_ADD = 11'b10001011000;
  localparam logic [DEC_W-1:0] OP_SUB = 11'b11001011000;
  localparam logic [DEC_W-1:0] OP_AND = 11'b10001010000;
  localparam logic [DEC_W-1:0] OP_ORR = 11'b10101010000;
  localparam logic [DEC_W-1:0] OP_EOR = 11'b11001010000;
  localparam logic [DEC_W-1:0] OP_LSL = 11'b11010011011;
  localparam logic [DEC_W-1:0] OP_LSR = 11'b11010011010;
  localparam logic [DEC_W-1:0] OP_MUL = 11'b10011011000;

  typedef enum logic [1:0] {
    AOP_LDST  = 2'b00,
    AOP_BR    = 2'b01,
    AOP_RTYPE = 2'b10,
    AOP_RSVD  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_MULTI = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: purely combinational opcode/alu_op decoder.
//   opcode_i   [OPCODE_W] instruction opcode; only the top 11 bits are decoded
//   alu_op_i   [2]        00 ld/st, 01 branch, 10 R-format, 11 reserved
//   code_o     [4]        ALU control code
//   is_mul_o              decoded a (legal) multiply
//   illegal_o             unsupported encoding; code_o falls back to ADD
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int OPCODE_W   = 11,
  parameter int ENABLE_MUL = 1
) (
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic [1:0]          alu_op_i,
  output logic [CODE_W-1:0]   code_o,
  output logic                is_mul_o,
  output logic                illegal_o
);

  logic [DEC_W-1:0] key;
  assign key = opcode_i[OPCODE_W-1 -: DEC_W];

  // Extra opcode LSBs are intentionally ignored.
  if (OPCODE_W > DEC_W) begin : g_lsb
    logic unused_lsbs;
    assign unused_lsbs = ^opcode_i[OPCODE_W-DEC_W-1:0];
  end

  always_comb begin
    code_o    = ALU_ADD;
    is_mul_o  = 1'b0;
    illegal_o = 1'b0;
    case (alu_op_i)
      AOP_LDST: code_o = ALU_ADD;
      AOP_BR:   code_o = ALU_PASSB;
      AOP_RTYPE: begin
        case (key)
          OP_ADD: code_o = ALU_ADD;
          OP_SUB: code_o = ALU_SUB;
          OP_AND: code_o = ALU_AND;
          OP_ORR: code_o = ALU_OR;
          OP_EOR: code_o = ALU_EOR;
          OP_LSL: code_o = ALU_LSL;
          OP_LSR: code_o = ALU_LSR;
          OP_MUL: begin
            if (ENABLE_MUL != 0) begin
              code_o   = ALU_MUL;
              is_mul_o = 1'b1;
            end else begin
              illegal_o = 1'b1;
            end
          end
          default: illegal_o = 1'b1;
        endcase
      end
      default: illegal_o = 1'b1;  // reserved alu_op
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: sequential ALU control decoder with valid/ready on both sides.
//   clk, rst             clock, async active-high reset
//   in_valid/in_ready    request handshake (opcode, alu_op)
//   alu_ctrl [CTRL_W]    registered control word, held from accept to next accept
//   busy                 multi-cycle MUL in progress
//   illegal              accepted request was unsupported (qualify with out_valid)
//   out_valid/out_ready  completion handshake
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int OPCODE_W   = 11,
  parameter int CTRL_W     = 4,
  parameter int MUL_LAT    = 4,
  parameter int ENABLE_MUL = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [1:0]          alu_op,
  output logic [CTRL_W-1:0]   alu_ctrl,
  output logic                busy,
  output logic                illegal,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int              CNT_W    = $clog2(MUL_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);
  localparam bit              MUL_MULTI = (MUL_LAT > 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CTRL_W-1:0]   ctrl_q;
  logic                ill_q;

  logic [CODE_W-1:0]   dec_code;
  logic                dec_mul;
  logic                dec_ill;
  logic                accept;
  logic                go_multi;

  alu_ctrl_decode #(
    .OPCODE_W   (OPCODE_W),
    .ENABLE_MUL (ENABLE_MUL)
  ) u_dec (
    .opcode_i  (opcode),
    .alu_op_i  (alu_op),
    .code_o    (dec_code),
    .is_mul_o  (dec_mul),
    .illegal_o (dec_ill)
  );

  assign accept   = in_valid && in_ready;
  assign go_multi = dec_mul && MUL_MULTI;

  // State register (FSM state + MUL countdown).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          state_d = go_multi ? ST_MULTI : ST_DONE;
          cnt_d   = go_multi ? CNT_LOAD : '0;
        end else if (state_q == ST_DONE && out_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_MULTI: begin
        // Leaving at count 1 makes out_valid land exactly MUL_LAT cycles after accept.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic. in_ready depends on out_ready so a completed result can be
  // retired and a new request accepted in the same cycle.
  always_comb begin
    in_ready  = (state_q == ST_IDLE) || (state_q == ST_DONE && out_ready);
    busy      = (state_q == ST_MULTI);
    out_valid = (state_q == ST_DONE);
  end

  // Result registers: only written on accept, so they stay stable through
  // MULTI and any backpressure in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= CTRL_W'(ALU_ADD);
      ill_q  <= 1'b0;
    end else if (accept) begin
      ctrl_q <= CTRL_W'(dec_code);
      ill_q  <= dec_ill;
    end
  end

  assign alu_ctrl = ctrl_q;
  assign illegal  = ill_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
module tb_alu_ctrl_seq;

  localparam int MUL_LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // Main DUT (defaults).
  logic        in_valid, in_ready, busy, illegal, out_valid, out_ready;
  logic [10:0] opcode;
  logic [1:0]  alu_op;
  logic [3:0]  alu_ctrl;

  // Second DUT: MUL disabled, wider opcode/control fields.
  logic        in_valid2, in_ready2, busy2, illegal2, out_valid2, out_ready2;
  logic [12:0] opcode2;
  logic [1:0]  alu_op2;
  logic [5:0]  alu_ctrl2;

  alu_ctrl_seq #(.OPCODE_W(11), .CTRL_W(4), .MUL_LAT(MUL_LAT), .ENABLE_MUL(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .alu_op(alu_op), .alu_ctrl(alu_ctrl), .busy(busy),
    .illegal(illegal), .out_valid(out_valid), .out_ready(out_ready)
  );

  alu_ctrl_seq #(.OPCODE_W(13), .CTRL_W(6), .MUL_LAT(3), .ENABLE_MUL(0)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .opcode(opcode2), .alu_op(alu_op2), .alu_ctrl(alu_ctrl2), .busy(busy2),
    .illegal(illegal2), .out_valid(out_valid2), .out_ready(out_ready2)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: one outstanding op, "wait" = cycles left before its result shows.
  bit m_have;
  int m_wait;
  int m_ctrl;
  bit m_ill;

  function automatic void m_reset();
    m_have = 0; m_wait = 0; m_ctrl = 2; m_ill = 0;
  endfunction

  function automatic void ref_dec(input logic [10:0] op, input logic [1:0] aop, input bit en_mul,
                                  output int code, output bit ill, output bit mul);
    code = 2; ill = 0; mul = 0;
    if (aop == 2'b01) code = 7;
    else if (aop == 2'b11) ill = 1;
    else if (aop == 2'b10) begin
      case (op)
        11'b10001011000: code = 2;
        11'b11001011000: code = 6;
        11'b10001010000: code = 0;
        11'b10101010000: code = 1;
        11'b11001010000: code = 3;
        11'b11010011011: code = 4;
        11'b11010011010: code = 5;
        11'b10011011000: if (en_mul) begin code = 8; mul = 1; end else ill = 1;
        default:         ill = 1;
      endcase
    end
  endfunction

  // Called #1 after inputs settle: compare outputs, then advance the model at posedge.
  task automatic cycle_check();
    bit e_ov, e_busy, e_rdy, mul;
    e_ov   = m_have && (m_wait == 0);
    e_busy = m_have && (m_wait > 0);
    e_rdy  = !m_have || (e_ov && out_ready);
    chk("out_valid", out_valid, e_ov);
    chk("busy",      busy,      e_busy);
    chk("in_ready",  in_ready,  e_rdy);
    chk("alu_ctrl",  alu_ctrl,  m_ctrl);
    chk("illegal",   illegal,   m_ill);
    @(posedge clk);
    if (in_valid && e_rdy) begin
      ref_dec(opcode, alu_op, 1'b1, m_ctrl, m_ill, mul);
      m_have = 1;
      m_wait = mul ? MUL_LAT - 1 : 0;
    end else if (e_ov && out_ready) begin
      m_have = 0;
    end else if (e_busy) begin
      m_wait--;
    end
  endtask

  task automatic apply(input bit v, input logic [1:0] aop, input logic [10:0] op, input bit ordy);
    @(negedge clk);
    in_valid = v; alu_op = aop; opcode = op; out_ready = ordy;
    #1;
    cycle_check();
  endtask

  logic [10:0] ops [8] = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000,
                           11'b11001010000, 11'b11010011011, 11'b11010011010, 11'b10011011000};

  initial begin
    rst = 1'b1;
    in_valid = 0; opcode = '0; alu_op = 2'b00; out_ready = 1;
    in_valid2 = 0; opcode2 = '0; alu_op2 = 2'b00; out_ready2 = 1;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy",      busy,      0);
    chk("rst_alu_ctrl",  alu_ctrl,  4'b0010);
    chk("rst_illegal",   illegal,   0);
    chk("rst_in_ready",  in_ready,  1);
    rst = 1'b0;

    // SUB, then idle: result next cycle, then back to idle.
    apply(1, 2'b10, 11'b11001011000, 1);
    apply(0, 2'b00, '0, 1);
    chk("sub_code", alu_ctrl, 4'b0110);
    apply(0, 2'b00, '0, 1);

    // MUL latency.
    apply(1, 2'b10, ops[7], 1);
    repeat (5) apply(0, 2'b00, '0, 1);

    // Illegal encodings.
    apply(1, 2'b10, 11'b11111111111, 1);
    apply(1, 2'b11, 11'b10001010000, 1);
    apply(0, 2'b00, '0, 1);

    // Backpressure on LSL, then same-cycle accept of a branch.
    apply(1, 2'b10, ops[5], 0);
    repeat (5) apply(0, 2'b00, '0, 0);
    apply(1, 2'b01, '0, 1);
    apply(0, 2'b00, '0, 1);
    chk("passb_code", alu_ctrl, 4'b0111);

    // Back-to-back stream.
    apply(1, 2'b00, '0, 1);
    apply(1, 2'b01, '0, 1);
    apply(1, 2'b10, ops[2], 1);
    apply(1, 2'b10, ops[3], 1);
    apply(1, 2'b10, ops[4], 1);
    apply(1, 2'b10, ops[6], 1);
    apply(0, 2'b00, '0, 1);
    apply(0, 2'b00, '0, 1);

    // Async reset two cycles into a MUL.
    apply(1, 2'b10, ops[7], 1);
    apply(0, 2'b00, '0, 1);
    apply(0, 2'b00, '0, 1);
    @(negedge clk);
    chk("busy_pre_rst", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy",      busy,      0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_alu_ctrl",  alu_ctrl,  4'b0010);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    apply(1, 2'b10, ops[0], 1);
    apply(0, 2'b00, '0, 1);
    chk("post_rst_ov", out_valid, 1);
    apply(0, 2'b00, '0, 1);

    // Second DUT: MUL disabled decodes as illegal single-cycle; opcode LSBs ignored.
    @(negedge clk);
    in_valid2 = 1; alu_op2 = 2'b10; opcode2 = {11'b10011011000, 2'b11};
    @(posedge clk);
    @(negedge clk);
    in_valid2 = 1; opcode2 = {11'b10001010000, 2'b01};
    #1;
    chk("d2_ov",    out_valid2, 1);
    chk("d2_busy",  busy2,      0);
    chk("d2_ill",   illegal2,   1);
    chk("d2_ctrl",  alu_ctrl2,  6'b000010);
    chk("d2_rdy",   in_ready2,  1);
    @(posedge clk);
    @(negedge clk);
    in_valid2 = 0;
    #1;
    chk("d2_and_ctrl", alu_ctrl2, 6'b000000);
    chk("d2_and_ill",  illegal2,  0);
    chk("d2_and_ov",   out_valid2, 1);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      int r;
      logic [1:0] aop;
      logic [10:0] op;
      r = $urandom_range(0, 9);
      op = (r < 8) ? ops[r] : 11'($urandom);
      r = $urandom_range(0, 9);
      aop = (r < 6) ? 2'b10 : (r < 8) ? 2'b00 : (r == 8) ? 2'b01 : 2'b11;
      apply($urandom_range(0, 3) != 0, aop, op, $urandom_range(0, 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
